pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage RV32IM pipeline. It watches the decode, execute and memory stage registers, the execute unit's divider busy flag and the EBREAK halt request. It drives every stage's stall and flush line, plus the data-hazard qualifier the execute unit uses to gate divider start. It also owns the debug halt/step state machine and two 32-bit event counters exposed to the CSR file.

## Interface
- `DRAIN_CYCLES`, default 2: cycles spent draining M/W after a halt request before `halted_o` asserts (range 1-7).
- `clk_i` in 1: system clock, all state on rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `FD_rs1Id_i`, `FD_rs2Id_i` in 5 each: source register IDs of the instruction in decode.
- `FD_readsRs1_i`, `FD_readsRs2_i` in 1 each: decode instruction actually reads rs1/rs2.
- `DE_isLoad_i`, `DE_isCSR_i` in 1 each: instruction in execute is a load / CSR access (result not forwardable from EM).
- `DE_wbEnable_i` in 1: execute instruction writes back.
- `DE_rdId_i` in 5: execute instruction destination register.
- `aluBusy_i` in 1: execute unit divider busy.
- `EM_correctPC_i` in 1: memory stage carries a PC correction (mispredict).
- `HALT_i` in 1: EBREAK present in execute.
- `resume_i` in 1: debugger single-step/resume request.
- `F_stall_o`, `D_stall_o`, `E_stall_o` out 1 each: hold IF, FD, DE/EM pipeline registers.
- `D_flush_o`, `E_flush_o`, `M_flush_o` out 1 each: insert NOP into FD, DE, EM registers.
- `dataHazard_o` out 1: load-use hazard this cycle.
- `halted_o` out 1: core halted.
- `stallCnt_o` out 32: count of hazard stall cycles.
- `flushCnt_o` out 32: count of mispredict flush cycles.

## Operation
- `loadUse` = (`DE_isLoad_i` | `DE_isCSR_i`) & `DE_wbEnable_i` & `DE_rdId_i` != 0 & ((`FD_readsRs1_i` & `FD_rs1Id_i` == `DE_rdId_i`) | (`FD_readsRs2_i` & `FD_rs2Id_i` == `DE_rdId_i`)).
- FSM states: RUN, DRAIN, HALTED, STEP. The halt set is DRAIN and HALTED.
- Outputs in RUN and STEP follow a fixed priority. The first matching row wins; all other outputs are 0.
  - (1) `EM_correctPC_i`: `D_flush_o` = `E_flush_o` = 1, no stalls.
  - (2) `aluBusy_i`: `F_stall_o` = `D_stall_o` = `E_stall_o` = 1, `M_flush_o` = 1.
  - (3) `loadUse`: `F_stall_o` = `D_stall_o` = 1, `E_flush_o` = 1.
- `dataHazard_o` = `loadUse` in every state, independent of the priority rows.
- DRAIN/HALTED outputs: `F_stall_o` = `D_stall_o` = `E_stall_o` = 1 and `M_flush_o` = 1. All other stall/flush outputs are 0.
- FSM transitions:
  - RUN → DRAIN when `HALT_i` & !`EM_correctPC_i` & !`aluBusy_i`. The drain counter loads `DRAIN_CYCLES`-1.
  - DRAIN decrements the counter and goes to HALTED when it reads 0.
  - HALTED → STEP when `resume_i`.
  - STEP: `HALT_i` is ignored for this one cycle and the EBREAK advances out of execute. Next state is RUN.
  - A `HALT_i` during a correction (wrong path) or while `aluBusy_i` is high is ignored that cycle.
- `halted_o` = 1 exactly in HALTED. `resume_i` outside HALTED is ignored.
- `stallCnt_o` increments on cycles in RUN/STEP where `F_stall_o` = 1 (rows 2 or 3).
- `flushCnt_o` increments on cycles where `D_flush_o` = 1.
- Both counters are modulo 2^32, wrapping from 0xFFFFFFFF to 0.

## Timing
- All stall/flush/hazard outputs are combinational from the current inputs and the registered state, so they act in the same cycle.
- State, drain counter and event counters update on the rising edge.
- Reset: state = RUN, drain counter = 0, both counters = 0, `halted_o` = 0.
  - During reset the stall/flush outputs still evaluate per the RUN rules.
  - Reset asserted in DRAIN/HALTED/STEP returns to RUN on the next edge.
- Halt latency: `HALT_i` in RUN at cycle t gives DRAIN at t+1 and `halted_o` = 1 at t+1+`DRAIN_CYCLES`.
- Resume: `resume_i` at cycle h in HALTED gives STEP at h+1, where the stalls drop, and RUN at h+2.
- `aluBusy_i` and `loadUse` together: row 2 wins and `dataHazard_o` is still 1, so the divider does not restart.

## Test plan
- Load-use: `DE_isLoad_i`=1, `DE_rdId_i`=5, `DE_wbEnable_i`=1, `FD_rs2Id_i`=5, `FD_readsRs2_i`=1 → `F_stall_o`=`D_stall_o`=`E_flush_o`=`dataHazard_o`=1, `stallCnt_o` 0→1. Repeat with rd=0 → all 0.
- Divider: `aluBusy_i` high 33 cycles → F/D/E stall and `M_flush_o` for exactly 33 cycles, `stallCnt_o`=33. Add a simultaneous `EM_correctPC_i` in the first cycle → that cycle shows only `D_flush_o`=`E_flush_o`=1.
- Mispredict plus load-use in the same cycle → only the flushes assert, no stalls, `flushCnt_o`=1.
- Halt with `DRAIN_CYCLES`=2: `HALT_i` held high → `halted_o` rises 3 cycles later. Pulse `resume_i` → one STEP cycle with no stalls while `HALT_i`=1, then back to RUN.
- `HALT_i` coincident with `EM_correctPC_i` → no DRAIN entry. Reset asserted mid-DRAIN → RUN, counters 0.
- Preload `stallCnt_o` to 0xFFFFFFFF via 2^32-1 forced stall cycles (or a bench force) → next stall wraps it to 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-side hazard inputs and stall/flush/debug outputs of the hazard controller
interface pipeline_hazard_ctrl_if;
  logic [4:0] FD_rs1Id_i, FD_rs2Id_i, DE_rdId_i;
  logic FD_readsRs1_i, FD_readsRs2_i;
  logic DE_isLoad_i, DE_isCSR_i, DE_wbEnable_i;
  logic aluBusy_i, EM_correctPC_i, HALT_i, resume_i;
  logic F_stall_o, D_stall_o, E_stall_o;
  logic D_flush_o, E_flush_o, M_flush_o;
  logic dataHazard_o, halted_o;
  logic [31:0] stallCnt_o, flushCnt_o;
  modport master (
    output FD_rs1Id_i, FD_rs2Id_i, DE_rdId_i, FD_readsRs1_i, FD_readsRs2_i,
           DE_isLoad_i, DE_isCSR_i, DE_wbEnable_i, aluBusy_i, EM_correctPC_i, HALT_i, resume_i,
    input  F_stall_o, D_stall_o, E_stall_o, D_flush_o, E_flush_o, M_flush_o,
           dataHazard_o, halted_o, stallCnt_o, flushCnt_o
  );
  modport slave (
    input  FD_rs1Id_i, FD_rs2Id_i, DE_rdId_i, FD_readsRs1_i, FD_readsRs2_i,
           DE_isLoad_i, DE_isCSR_i, DE_wbEnable_i, aluBusy_i, EM_correctPC_i, HALT_i, resume_i,
    output F_stall_o, D_stall_o, E_stall_o, D_flush_o, E_flush_o, M_flush_o,
           dataHazard_o, halted_o, stallCnt_o, flushCnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush priority, load-use detection, debug halt/step FSM and event counters
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input logic clk_i,
  input logic reset_i,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2, STEP = 2'd3;
  logic [1:0] state;
  logic [2:0] drain_cnt;
  logic [31:0] stall_cnt, flush_cnt;
  logic load_use, halt_set, corr, busy_row, lu_row, f_stall, d_flush;
  assign load_use = (hz.DE_isLoad_i | hz.DE_isCSR_i) & hz.DE_wbEnable_i & (hz.DE_rdId_i != 5'd0) &
                    ((hz.FD_readsRs1_i & (hz.FD_rs1Id_i == hz.DE_rdId_i)) |
                     (hz.FD_readsRs2_i & (hz.FD_rs2Id_i == hz.DE_rdId_i)));
  assign halt_set = (state == DRAIN) | (state == HALTED);
  // Priority rows only apply outside the halt set; a correction masks everything below it.
  assign corr     = !halt_set & hz.EM_correctPC_i;
  assign busy_row = !halt_set & !hz.EM_correctPC_i & hz.aluBusy_i;
  assign lu_row   = !halt_set & !hz.EM_correctPC_i & !hz.aluBusy_i & load_use;
  assign f_stall  = busy_row | lu_row;
  assign d_flush  = corr;
  assign hz.F_stall_o    = halt_set | f_stall;
  assign hz.D_stall_o    = halt_set | f_stall;
  assign hz.E_stall_o    = halt_set | busy_row;
  assign hz.D_flush_o    = d_flush;
  assign hz.E_flush_o    = corr | lu_row;
  assign hz.M_flush_o    = halt_set | busy_row;
  assign hz.dataHazard_o = load_use;
  assign hz.halted_o     = state == HALTED;
  assign hz.stallCnt_o   = stall_cnt;
  assign hz.flushCnt_o   = flush_cnt;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= RUN;
      drain_cnt <= 3'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, f_stall};
      flush_cnt <= flush_cnt + {31'd0, d_flush};
      case (state)
        RUN: if (hz.HALT_i & !hz.EM_correctPC_i & !hz.aluBusy_i) begin
          state     <= DRAIN;
          drain_cnt <= 3'(DRAIN_CYCLES - 1);
        end
        DRAIN: if (drain_cnt == 3'd0) state <= HALTED;
               else drain_cnt <= drain_cnt - 3'd1;
        HALTED: if (hz.resume_i) state <= STEP;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vector table plus hand-written divider, halt/step, reset and wrap sequences
module tb_pipeline_hazard_ctrl;
  logic clk_i = 1'b0, reset_i = 1'b1;
  int checks = 0, fails = 0;
  logic [31:0] exp_stall = 0, exp_flush = 0;
  pipeline_hazard_ctrl_if hz ();
  pipeline_hazard_ctrl #(.DRAIN_CYCLES(2)) dut (.clk_i(clk_i), .reset_i(reset_i), .hz(hz.slave));
  always #5 clk_i = ~clk_i;
  logic [6:0] outs;
  assign outs = {hz.F_stall_o, hz.D_stall_o, hz.E_stall_o, hz.D_flush_o, hz.E_flush_o, hz.M_flush_o, hz.dataHazard_o};
  typedef struct {
    logic [4:0] rs1, rs2;
    logic r1, r2, ld, csr, wb;
    logic [4:0] rd;
    logic busy, corr;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[11];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask
  task automatic apply(input vec_t v);
    hz.FD_rs1Id_i = v.rs1; hz.FD_rs2Id_i = v.rs2;
    hz.FD_readsRs1_i = v.r1; hz.FD_readsRs2_i = v.r2;
    hz.DE_isLoad_i = v.ld; hz.DE_isCSR_i = v.csr; hz.DE_wbEnable_i = v.wb;
    hz.DE_rdId_i = v.rd; hz.aluBusy_i = v.busy; hz.EM_correctPC_i = v.corr;
  endtask
  vec_t idle, lu, busy, corr;
  initial begin
    idle = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b0};
    lu   = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 7'b1100101};
    busy = idle; busy.busy = 1'b1; busy.exp = 7'b1110010;
    corr = idle; corr.corr = 1'b1; corr.exp = 7'b0001100;
    vecs[0]  = lu;
    vecs[1]  = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 7'b0};
    vecs[2]  = '{5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 7'b1100101};
    vecs[3]  = '{5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 7'b0};
    vecs[4]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 7'b0};
    vecs[5]  = busy;
    vecs[6]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 7'b1110011};
    vecs[7]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 7'b0001101};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 7'b0001100};
    vecs[9]  = idle;
    vecs[10] = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 7'b0};
    apply(idle);
    hz.HALT_i = 1'b0; hz.resume_i = 1'b0;
    cyc(); cyc();
    check("reset_halted", 32'(hz.halted_o), 0);
    check("reset_stallcnt", hz.stallCnt_o, 0);
    check("reset_flushcnt", hz.flushCnt_o, 0);
    apply(lu); #1;
    check("reset_run_rules", 32'(outs), 32'(lu.exp));
    cyc();
    check("reset_holds_cnt", hz.stallCnt_o, 0);
    reset_i = 1'b0;
    foreach (vecs[i]) begin
      apply(vecs[i]); #1;
      check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
      exp_stall += 32'(vecs[i].exp[6]);
      exp_flush += 32'(vecs[i].exp[3]);
      cyc();
      check($sformatf("vec%0d_stallcnt", i), hz.stallCnt_o, exp_stall);
    end
    check("table_flushcnt", hz.flushCnt_o, exp_flush);
    apply(busy);
    for (int i = 0; i < 33; i++) begin
      #1 check($sformatf("div_cyc%0d", i), 32'(outs), 32'(busy.exp));
      cyc();
    end
    exp_stall += 33;
    apply(idle); #1;
    check("div_done", 32'(outs), 0);
    check("div_stallcnt", hz.stallCnt_o, exp_stall);
    apply(busy); hz.EM_correctPC_i = 1'b1; #1;
    check("div_corr_first", 32'(outs), 32'(corr.exp));
    cyc(); exp_flush += 1;
    hz.EM_correctPC_i = 1'b0; #1;
    check("div_after_corr", 32'(outs), 32'(busy.exp));
    cyc(); exp_stall += 1;
    apply(idle);
    check("div_corr_flushcnt", hz.flushCnt_o, exp_flush);
    hz.HALT_i = 1'b1; #1;
    check("halt_req_run", 32'(outs), 0);
    cyc();
    check("drain1_outs", 32'(outs), 32'(busy.exp));
    check("drain1_halted", 32'(hz.halted_o), 0);
    apply(lu); #1;
    check("drain_hazard", 32'(outs), 32'b1110011);
    cyc(); apply(idle);
    check("drain2_halted", 32'(hz.halted_o), 0);
    cyc();
    check("halted_at_3", 32'(hz.halted_o), 1);
    check("halted_outs", 32'(outs), 32'(busy.exp));
    cyc();
    check("halted_stays", 32'(hz.halted_o), 1);
    check("halt_no_stallcnt", hz.stallCnt_o, exp_stall);
    hz.resume_i = 1'b1;
    cyc(); hz.resume_i = 1'b0; #1;
    check("step_halted", 32'(hz.halted_o), 0);
    check("step_outs", 32'(outs), 0);
    hz.HALT_i = 1'b0;
    cyc();
    check("run_after_step", 32'(outs), 0);
    cyc();
    check("run_stays", 32'(outs), 0);
    hz.resume_i = 1'b1;
    cyc(); hz.resume_i = 1'b0;
    check("resume_in_run", 32'(outs) | 32'(hz.halted_o), 0);
    hz.HALT_i = 1'b1; hz.EM_correctPC_i = 1'b1;
    cyc(); exp_flush += 1;
    hz.HALT_i = 1'b0; hz.EM_correctPC_i = 1'b0; #1;
    check("halt_corr_ignored", 32'(outs), 0);
    hz.HALT_i = 1'b1; hz.aluBusy_i = 1'b1;
    cyc(); exp_stall += 1;
    hz.HALT_i = 1'b0; hz.aluBusy_i = 1'b0; #1;
    check("halt_busy_ignored", 32'(outs), 0);
    check("halt_ign_stallcnt", hz.stallCnt_o, exp_stall);
    check("halt_ign_flushcnt", hz.flushCnt_o, exp_flush);
    hz.HALT_i = 1'b1;
    cyc(); hz.HALT_i = 1'b0;
    check("drain_before_reset", 32'(outs), 32'(busy.exp));
    reset_i = 1'b1;
    cyc(); reset_i = 1'b0; #1;
    exp_stall = 0; exp_flush = 0;
    check("reset_mid_drain_outs", 32'(outs), 0);
    check("reset_mid_drain_stall", hz.stallCnt_o, 0);
    check("reset_mid_drain_flush", hz.flushCnt_o, 0);
    cyc(); cyc(); cyc();
    check("reset_no_halt", 32'(hz.halted_o), 0);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt;
    check("preload", hz.stallCnt_o, 32'hFFFF_FFFF);
    apply(lu);
    cyc(); apply(idle);
    check("stallcnt_wrap", hz.stallCnt_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
